// File: rtl/sn_vc_output_allocator_pkg.sv
// Shared SiliconNet switch types: port/VC widths, credit width and allocator states.
package sn_vc_output_allocator_pkg;

  localparam int SN_NUM_PORTS                 = 8;
  localparam int SN_NUM_VCS                   = 4;
  localparam int SN_FLITS_PER_PORT_DOWNSTREAM = 32;

  localparam int SN_PORT_WIDTH   = $clog2(SN_NUM_PORTS);
  localparam int SN_VC_WIDTH     = (SN_NUM_VCS == 1) ? 1 : $clog2(SN_NUM_VCS);
  localparam int SN_CREDIT_WIDTH = $clog2(SN_FLITS_PER_PORT_DOWNSTREAM + 1);

  typedef logic [SN_VC_WIDTH-1:0]   vc_t;
  typedef logic [SN_PORT_WIDTH-1:0] port_t;

  typedef enum logic [1:0] {
    ALLOC_IDLE,
    ALLOC_PKT,
    ALLOC_MSG
  } alloc_state_t;

endpackage

// File: rtl/sn_vc_output_allocator_if.sv
// Raise/grant/credit bundle between the input-port raise logic and one output allocator.
interface sn_vc_output_allocator_if #(
  parameter int NUM_PORTS      = 8,
  parameter int NUM_VCS        = 4,
  parameter int CREDITS_PER_VC = 32
);
  localparam int PORT_WIDTH   = $clog2(NUM_PORTS);
  localparam int VC_WIDTH     = (NUM_VCS == 1) ? 1 : $clog2(NUM_VCS);
  localparam int CREDIT_WIDTH = $clog2(CREDITS_PER_VC + 1);

  logic [NUM_PORTS-1:0]              raise_valid;
  logic [NUM_PORTS*VC_WIDTH-1:0]     raise_vc;
  logic [NUM_PORTS-1:0]              raise_last;
  logic [NUM_PORTS-1:0]              raise_msg_last;
  logic                              grant_valid;
  logic [PORT_WIDTH-1:0]             grant_src_port;
  logic [NUM_PORTS-1:0]              grant_one_hot;
  logic [VC_WIDTH-1:0]               grant_vc;
  logic                              grant_first;
  logic                              credit_in_valid;
  logic [VC_WIDTH-1:0]               credit_in_vc;
  logic [NUM_VCS*CREDIT_WIDTH-1:0]   credit_count;
  logic                              credit_err;

  modport master (
    output raise_valid, raise_vc, raise_last, raise_msg_last, credit_in_valid, credit_in_vc,
    input  grant_valid, grant_src_port, grant_one_hot, grant_vc, grant_first,
           credit_count, credit_err
  );

  modport slave (
    input  raise_valid, raise_vc, raise_last, raise_msg_last, credit_in_valid, credit_in_vc,
    output grant_valid, grant_src_port, grant_one_hot, grant_vc, grant_first,
           credit_count, credit_err
  );
endinterface

// File: rtl/sn_rr_arbiter.sv
// Combinational round-robin arbiter: first requester strictly after ptr wins.
module sn_rr_arbiter #(
  parameter int NUM_PORTS  = 8,
  parameter int PORT_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_WIDTH-1:0] ptr,
  output logic [NUM_PORTS-1:0]  grant,
  output logic [PORT_WIDTH-1:0] idx,
  output logic                  any
);
  always_comb begin
    int cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(ptr) + k) % NUM_PORTS;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = PORT_WIDTH'(cand);
      end
    end
  end
endmodule

// File: rtl/sn_vc_output_allocator.sv
// Per-output switch allocator: round-robin over sources, packet/message lock, per-VC credits.
module sn_vc_output_allocator
  import sn_vc_output_allocator_pkg::*;
#(
  parameter int NUM_PORTS      = SN_NUM_PORTS,
  parameter int NUM_VCS        = SN_NUM_VCS,
  parameter int CREDITS_PER_VC = SN_FLITS_PER_PORT_DOWNSTREAM,
  parameter int MSG_LOCK       = 0
) (
  input logic                   clk,
  input logic                   rst,
  sn_vc_output_allocator_if.slave bus
);
  localparam int PORT_WIDTH   = $clog2(NUM_PORTS);
  localparam int VC_WIDTH     = (NUM_VCS == 1) ? 1 : $clog2(NUM_VCS);
  localparam int CREDIT_WIDTH = $clog2(CREDITS_PER_VC + 1);

  alloc_state_t             state_reg;
  logic [PORT_WIDTH-1:0]    owner_reg;
  logic [PORT_WIDTH-1:0]    rr_ptr_reg;
  logic [VC_WIDTH-1:0]      vc_reg;
  logic [CREDIT_WIDTH-1:0]  credit_reg [NUM_VCS];
  logic                     credit_err_reg;

  logic [NUM_VCS-1:0]       vc_has_credit, consume, credit_ret, overflow;
  logic [NUM_PORTS-1:0]     req_ok, eligible, arb_one_hot, owner_one_hot;
  logic [PORT_WIDTH-1:0]    arb_idx;
  logic                     arb_any;

  logic                     grant_valid, grant_first, end_cond;
  logic [PORT_WIDTH-1:0]    grant_src;
  logic [VC_WIDTH-1:0]      grant_vc;
  logic [NUM_PORTS-1:0]     grant_oh;

  generate
    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
      assign vc_has_credit[gi] = (credit_reg[gi] != '0);
      assign consume[gi]       = grant_valid && grant_first && (grant_vc == VC_WIDTH'(gi));
      assign credit_ret[gi]    = bus.credit_in_valid && (bus.credit_in_vc == VC_WIDTH'(gi));
      // A return that coincides with a consume on the same VC cancels and cannot overflow.
      assign overflow[gi]      = credit_ret[gi] && !consume[gi] &&
                                 (credit_reg[gi] == CREDIT_WIDTH'(CREDITS_PER_VC));
      assign bus.credit_count[gi*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_reg[gi];
    end
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign eligible[gi]      = bus.raise_valid[gi] && req_ok[gi];
      assign owner_one_hot[gi] = (owner_reg == PORT_WIDTH'(gi));
    end
  endgenerate

  always_comb begin
    req_ok = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (bus.raise_vc[p*VC_WIDTH +: VC_WIDTH] == VC_WIDTH'(v) && vc_has_credit[v]) begin
          req_ok[p] = 1'b1;
        end
      end
    end
  end

  sn_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PORT_WIDTH(PORT_WIDTH)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .grant (arb_one_hot),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_first = 1'b0;
    grant_src   = '0;
    grant_vc    = '0;
    grant_oh    = '0;
    unique case (state_reg)
      ALLOC_IDLE: begin
        grant_valid = arb_any;
        grant_first = arb_any;
        grant_src   = arb_idx;
        grant_vc    = bus.raise_vc[int'(arb_idx)*VC_WIDTH +: VC_WIDTH];
        grant_oh    = arb_one_hot;
      end
      ALLOC_PKT: begin
        grant_valid = bus.raise_valid[owner_reg];
        grant_src   = owner_reg;
        grant_vc    = vc_reg;
        grant_oh    = owner_one_hot;
      end
      ALLOC_MSG: begin
        grant_valid = bus.raise_valid[owner_reg] && req_ok[owner_reg];
        grant_first = grant_valid;
        grant_src   = owner_reg;
        grant_vc    = bus.raise_vc[int'(owner_reg)*VC_WIDTH +: VC_WIDTH];
        grant_oh    = owner_one_hot;
      end
      default: ;
    endcase
    if (rst || !grant_valid) begin
      grant_valid = 1'b0;
      grant_first = 1'b0;
      grant_src   = '0;
      grant_vc    = '0;
      grant_oh    = '0;
    end
  end

  assign end_cond = bus.raise_last[grant_src] &&
                    ((MSG_LOCK == 0) || bus.raise_msg_last[grant_src]);

  assign bus.grant_valid    = grant_valid;
  assign bus.grant_first    = grant_first;
  assign bus.grant_src_port = grant_src;
  assign bus.grant_vc       = grant_vc;
  assign bus.grant_one_hot  = grant_oh;
  assign bus.credit_err     = credit_err_reg;

  // Pointer moves only on release, so bubbles inside a locked packet keep fairness intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ALLOC_IDLE;
      owner_reg  <= '0;
      vc_reg     <= '0;
      rr_ptr_reg <= PORT_WIDTH'(NUM_PORTS - 1);
    end else if (grant_valid) begin
      if (state_reg != ALLOC_PKT) begin
        owner_reg <= grant_src;
        vc_reg    <= grant_vc;
      end
      if (end_cond) begin
        state_reg  <= ALLOC_IDLE;
        rr_ptr_reg <= grant_src;
      end else if (bus.raise_last[grant_src]) begin
        state_reg <= ALLOC_MSG;
      end else begin
        state_reg <= ALLOC_PKT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VCS; v++) credit_reg[v] <= CREDIT_WIDTH'(CREDITS_PER_VC);
      credit_err_reg <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (consume[v] && !credit_ret[v]) begin
          credit_reg[v] <= credit_reg[v] - CREDIT_WIDTH'(1);
        end else if (credit_ret[v] && !consume[v] && !overflow[v]) begin
          credit_reg[v] <= credit_reg[v] + CREDIT_WIDTH'(1);
        end
      end
      credit_err_reg <= credit_err_reg | (|overflow);
    end
  end
endmodule
